// File: rtl/dmem_responder_if.sv
// Request/response data-bus bundle between the core's load/store port
// (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering one byte/half/word access at a time
// after a fixed number of wait states. Loads return extended lane data,
// stores return an acknowledge, and misaligned or out-of-range accesses
// come back flagged as errors without touching the array.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input logic            global_clk,
  input logic            reset,
  input logic            enable,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [2:0] WaitInit = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state_q, state_d;
  logic [2:0]  waitCnt_q, waitCnt_d;

  logic        capWe_q;
  logic [31:0] capAddr_q;
  logic [1:0]  capSize_q;
  logic        capUnsigned_q;
  logic [31:0] capWdata_q;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;

  logic        accWe;
  logic [31:0] accAddr;
  logic [1:0]  accSize;
  logic        accUnsigned;
  logic [31:0] accWdata;
  logic [ADDR_W-3:0] accIdx;
  logic        accErr;
  logic [31:0] memWord;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadVal;
  logic [3:0]  byteEn;
  logic [31:0] storeData;
  logic        memWrite;

  assign bus.req_ready = (state_q == ST_IDLE) & enable & reset;
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state logic: accept in IDLE, count wait states, hold the response until taken
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d   = ST_WAIT;
            waitCnt_d = WaitInit;
          end
        end
      end
      ST_WAIT: begin
        if (waitCnt_q == 3'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the live bus fields are used
  always_comb begin
    accWe       = capWe_q;
    accAddr     = capAddr_q;
    accSize     = capSize_q;
    accUnsigned = capUnsigned_q;
    accWdata    = capWdata_q;
    if (state_q == ST_IDLE) begin
      accWe       = bus.req_we;
      accAddr     = bus.req_addr;
      accSize     = bus.req_size;
      accUnsigned = bus.req_unsigned;
      accWdata    = bus.req_wdata;
    end
  end

  // Decode the access: fault detection, load lane extraction/extension and store lane steering
  always_comb begin
    accIdx   = accAddr[ADDR_W-1:2];
    memWord  = mem[accIdx];
    accErr   = (accSize == 2'd3) ||
               ((accSize == 2'd1) && accAddr[0]) ||
               ((accSize == 2'd2) && (accAddr[1:0] != 2'd0)) ||
               (accAddr[31:ADDR_W] != '0);

    case (accAddr[1:0])
      2'd0:    laneByte = memWord[7:0];
      2'd1:    laneByte = memWord[15:8];
      2'd2:    laneByte = memWord[23:16];
      default: laneByte = memWord[31:24];
    endcase
    laneHalf = accAddr[1] ? memWord[31:16] : memWord[15:0];

    case (accSize)
      2'd0:    loadVal = accUnsigned ? {24'd0, laneByte} : {{24{laneByte[7]}}, laneByte};
      2'd1:    loadVal = accUnsigned ? {16'd0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      default: loadVal = memWord;
    endcase

    case (accSize)
      2'd0: begin
        byteEn    = 4'b0001 << accAddr[1:0];
        storeData = {4{accWdata[7:0]}};
      end
      2'd1: begin
        byteEn    = accAddr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{accWdata[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = accWdata;
      end
    endcase

    memWrite = commit & accWe & ~accErr;
    err_d    = accErr;
    rdata_d  = (accErr | accWe) ? 32'd0 : loadVal;
  end

  // Control state and wait counter
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Capture the request on acceptance so the core may drop it afterwards
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      capWe_q       <= 1'b0;
      capAddr_q     <= 32'd0;
      capSize_q     <= 2'd0;
      capUnsigned_q <= 1'b0;
      capWdata_q    <= 32'd0;
    end else if (accept) begin
      capWe_q       <= bus.req_we;
      capAddr_q     <= bus.req_addr;
      capSize_q     <= bus.req_size;
      capUnsigned_q <= bus.req_unsigned;
      capWdata_q    <= bus.req_wdata;
    end
  end

  // Response payload is registered on the edge entering RESP and held there until taken
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Backing array: byte-lane writes on the commit edge, contents survive reset
  always_ff @(posedge global_clk) begin
    if (memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[accIdx][8*i +: 8] <= storeData[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances with 1, 0, 7 and 3 wait
// states share one request driver; a selector routes the request and output
// observation to one instance at a time.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic        reqValid;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqWdata;
  logic        rspReady;
  int          sel;

  int errCount   = 0;
  int checkCount = 0;

  logic [3:0]       readyVec;
  logic [3:0]       validVec;
  logic [3:0]       errVec;
  logic [3:0][31:0] rdataVec;

  logic        selReady;
  logic        selRspValid;
  logic        selErr;
  logic [31:0] selRdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    dmem_responder_if bus();

    assign bus.req_valid    = reqValid && (sel == g);
    assign bus.req_we       = reqWe;
    assign bus.req_addr     = reqAddr;
    assign bus.req_size     = reqSize;
    assign bus.req_unsigned = reqUnsigned;
    assign bus.req_wdata    = reqWdata;
    assign bus.rsp_ready    = rspReady;

    assign readyVec[g] = bus.req_ready;
    assign validVec[g] = bus.rsp_valid;
    assign errVec[g]   = bus.rsp_err;
    assign rdataVec[g] = bus.rsp_rdata;

    dmem_responder #(
      .ADDR_W      (12),
      .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 3)
    ) dut (
      .global_clk (clk),
      .reset      (rstN),
      .enable     (enable),
      .bus        (bus)
    );
  end

  assign selReady    = readyVec[sel[1:0]];
  assign selRspValid = validVec[sel[1:0]];
  assign selErr      = errVec[sel[1:0]];
  assign selRdata    = rdataVec[sel[1:0]];

  // Count one comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Present a request and return at the falling edge just before it is accepted
  task automatic issueReq(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input string tag);
    int n;
    sel         = d;
    reqWe       = we;
    reqAddr     = addr;
    reqSize     = size;
    reqUnsigned = uns;
    reqWdata    = wdata;
    reqValid    = 1'b1;
    #1;
    n = 0;
    while (!selReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "-accept"}, 32'(selReady), 32'd1);
  endtask

  // Count cycles from the acceptance cycle until rsp_valid is seen
  task automatic waitRsp(input logic dropEn, input string tag, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        reqValid = 1'b0;
        if (dropEn) enable = 1'b0;
      end
      if (selRspValid || lat >= 40) break;
    end
    checkOutput({tag, "-rspValid"}, 32'(selRspValid), 32'd1);
  endtask

  // Full transaction with rsp_ready high: response must last exactly one cycle
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input string tag,
                               output logic [31:0] rdata, output logic err, output int lat);
    issueReq(d, we, addr, size, uns, wdata, tag);
    waitRsp(1'b0, tag, lat);
    rdata = selRdata;
    err   = selErr;
    @(negedge clk);
    checkOutput({tag, "-oneCycle"}, 32'(selRspValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rstN        = 1'b0;
    enable      = 1'b1;
    reqValid    = 1'b1;
    reqWe       = 1'b1;
    reqAddr     = 32'h10;
    reqSize     = 2'd2;
    reqUnsigned = 1'b0;
    reqWdata    = 32'h0;
    rspReady    = 1'b1;
    sel         = 0;

    // Reset state with a request held high
    repeat (3) @(negedge clk);
    checkOutput("rst-ready", 32'(selReady), 32'd0);
    checkOutput("rst-valid", 32'(selRspValid), 32'd0);
    checkOutput("rst-rdata", selRdata, 32'd0);
    checkOutput("rst-err", 32'(selErr), 32'd0);
    reqValid = 1'b0;
    rstN     = 1'b1;
    #1;
    checkOutput("rel-ready", 32'(selReady), 32'd1);
    @(negedge clk);

    // Word round trip, one wait state
    applyStimulus(0, 1'b1, 32'h010, 2'd2, 1'b0, 32'hDEADBEEF, "wStore", rd, er, lat);
    checkOutput("wStore-err", 32'(er), 32'd0);
    checkOutput("wStore-lat", 32'(lat), 32'd2);
    applyStimulus(0, 1'b0, 32'h010, 2'd2, 1'b0, 32'h0, "wLoad", rd, er, lat);
    checkOutput("wLoad-data", rd, 32'hDEADBEEF);
    checkOutput("wLoad-err", 32'(er), 32'd0);
    checkOutput("wLoad-lat", 32'(lat), 32'd2);

    // Byte and half lanes
    applyStimulus(0, 1'b1, 32'h000, 2'd2, 1'b0, 32'h11223344, "pre0", rd, er, lat);
    applyStimulus(0, 1'b1, 32'h020, 2'd2, 1'b0, 32'h00000000, "pre20", rd, er, lat);
    applyStimulus(0, 1'b1, 32'h023, 2'd0, 1'b0, 32'hAAAAAA80, "sByte", rd, er, lat);
    checkOutput("sByte-err", 32'(er), 32'd0);
    applyStimulus(0, 1'b1, 32'h020, 2'd1, 1'b0, 32'h55557FFF, "sHalf", rd, er, lat);
    checkOutput("sHalf-err", 32'(er), 32'd0);
    applyStimulus(0, 1'b0, 32'h020, 2'd2, 1'b0, 32'h0, "lWord20", rd, er, lat);
    checkOutput("lWord20-data", rd, 32'h80007FFF);
    applyStimulus(0, 1'b0, 32'h023, 2'd0, 1'b0, 32'h0, "lSByte", rd, er, lat);
    checkOutput("lSByte-data", rd, 32'hFFFFFF80);
    applyStimulus(0, 1'b0, 32'h023, 2'd0, 1'b1, 32'h0, "lUByte", rd, er, lat);
    checkOutput("lUByte-data", rd, 32'h00000080);
    applyStimulus(0, 1'b0, 32'h020, 2'd1, 1'b0, 32'h0, "lSHalf0", rd, er, lat);
    checkOutput("lSHalf0-data", rd, 32'h00007FFF);
    applyStimulus(0, 1'b0, 32'h022, 2'd1, 1'b0, 32'h0, "lSHalf2", rd, er, lat);
    checkOutput("lSHalf2-data", rd, 32'hFFFF8000);
    applyStimulus(0, 1'b0, 32'h022, 2'd1, 1'b1, 32'h0, "lUHalf2", rd, er, lat);
    checkOutput("lUHalf2-data", rd, 32'h00008000);

    // Faulting accesses
    applyStimulus(0, 1'b0, 32'h021, 2'd1, 1'b0, 32'h0, "eHalf", rd, er, lat);
    checkOutput("eHalf-err", 32'(er), 32'd1);
    checkOutput("eHalf-data", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h012, 2'd2, 1'b0, 32'hFFFFFFFF, "eWord", rd, er, lat);
    checkOutput("eWord-err", 32'(er), 32'd1);
    applyStimulus(0, 1'b0, 32'h010, 2'd3, 1'b0, 32'h0, "eSize", rd, er, lat);
    checkOutput("eSize-err", 32'(er), 32'd1);
    checkOutput("eSize-data", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h00001000, 2'd2, 1'b0, 32'hFFFFFFFF, "eRangeSt", rd, er, lat);
    checkOutput("eRangeSt-err", 32'(er), 32'd1);
    applyStimulus(0, 1'b0, 32'h00001000, 2'd2, 1'b0, 32'h0, "eRangeLd", rd, er, lat);
    checkOutput("eRangeLd-err", 32'(er), 32'd1);
    checkOutput("eRangeLd-data", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h010, 2'd2, 1'b0, 32'h0, "keep10", rd, er, lat);
    checkOutput("keep10-data", rd, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h020, 2'd2, 1'b0, 32'h0, "keep20", rd, er, lat);
    checkOutput("keep20-data", rd, 32'h80007FFF);
    applyStimulus(0, 1'b0, 32'h000, 2'd2, 1'b0, 32'h0, "keep00", rd, er, lat);
    checkOutput("keep00-data", rd, 32'h11223344);

    // Backpressure: response held five cycles
    rspReady = 1'b0;
    issueReq(0, 1'b0, 32'h020, 2'd2, 1'b0, 32'h0, "bp");
    waitRsp(1'b0, "bp", lat);
    checkOutput("bp-lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp-valid", 32'(selRspValid), 32'd1);
      checkOutput("bp-data", selRdata, 32'h80007FFF);
      checkOutput("bp-err", 32'(selErr), 32'd0);
      checkOutput("bp-ready", 32'(selReady), 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    checkOutput("bp-takeValid", 32'(selRspValid), 32'd1);
    checkOutput("bp-takeReady", 32'(selReady), 32'd0);
    @(negedge clk);
    checkOutput("bp-doneValid", 32'(selRspValid), 32'd0);
    checkOutput("bp-doneReady", 32'(selReady), 32'd1);

    // Zero wait states
    applyStimulus(1, 1'b1, 32'h004, 2'd2, 1'b0, 32'hA5A5A5A5, "w0Store", rd, er, lat);
    checkOutput("w0Store-lat", 32'(lat), 32'd1);
    applyStimulus(1, 1'b0, 32'h004, 2'd2, 1'b0, 32'h0, "w0Load", rd, er, lat);
    checkOutput("w0Load-lat", 32'(lat), 32'd1);
    checkOutput("w0Load-data", rd, 32'hA5A5A5A5);
    applyStimulus(1, 1'b0, 32'h006, 2'd1, 1'b0, 32'h0, "w0Half", rd, er, lat);
    checkOutput("w0Half-data", rd, 32'hFFFFA5A5);

    // Seven wait states, enable dropped during the wait
    applyStimulus(2, 1'b1, 32'h100, 2'd2, 1'b0, 32'h0BADC0DE, "w7Store", rd, er, lat);
    checkOutput("w7Store-lat", 32'(lat), 32'd8);
    issueReq(2, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, "w7En");
    waitRsp(1'b1, "w7En", lat);
    checkOutput("w7En-lat", 32'(lat), 32'd8);
    checkOutput("w7En-data", selRdata, 32'h0BADC0DE);
    @(negedge clk);
    checkOutput("w7En-valid", 32'(selRspValid), 32'd0);
    checkOutput("w7En-ready0", 32'(selReady), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("w7En-ready1", 32'(selReady), 32'd0);
    enable = 1'b1;
    #1;
    checkOutput("w7En-ready2", 32'(selReady), 32'd1);
    @(negedge clk);

    // Reset in the middle of a three-wait-state store
    applyStimulus(3, 1'b1, 32'h040, 2'd2, 1'b0, 32'hCAFEF00D, "w3Pre", rd, er, lat);
    applyStimulus(3, 1'b0, 32'h040, 2'd2, 1'b0, 32'h0, "w3Load", rd, er, lat);
    checkOutput("w3Load-data", rd, 32'hCAFEF00D);
    checkOutput("w3Load-lat", 32'(lat), 32'd4);
    issueReq(3, 1'b1, 32'h040, 2'd2, 1'b0, 32'h12345678, "w3Abort");
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("w3Abort-inWait", 32'(selRspValid), 32'd0);
    rstN = 1'b0;
    #1;
    checkOutput("w3Abort-valid", 32'(selRspValid), 32'd0);
    checkOutput("w3Abort-data", selRdata, 32'd0);
    checkOutput("w3Abort-err", 32'(selErr), 32'd0);
    checkOutput("w3Abort-ready", 32'(selReady), 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(3, 1'b0, 32'h040, 2'd2, 1'b0, 32'h0, "w3Reload", rd, er, lat);
    checkOutput("w3Reload-data", rd, 32'hCAFEF00D);
    checkOutput("w3Reload-err", 32'(er), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder for the PiscesRV core's load/store port. It sits on the far end of the core's request/response data bus. It accepts one byte, halfword or word access at a time and applies a fixed, programmable wait-state count. It returns sign- or zero-extended load data or a store acknowledge, and flags misaligned or out-of-range accesses as errors. The core stalls on its handshake.

## Interface
- ADDR_W, 12, byte-address width of the backing array; depth = 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 1, extra cycles between acceptance and response; legal range 0..7.
- global_clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high = new requests may be accepted; low blocks acceptance only.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept; equals (state==IDLE) & enable & reset.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response held until taken.
- rsp_ready  input  1  core accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access faulted; qualified by rsp_valid.

## Operation
- FSM states:
  - IDLE: req_ready high if enable. On req_valid & req_ready, capture we, addr, size, unsigned and wdata. Go to RESP if WAIT_CYCLES==0, else go to WAIT with counter = WAIT_CYCLES-1.
  - WAIT: counter decrements each cycle. Go to RESP on the edge where counter==0.
  - RESP: rsp_valid high and rsp_rdata/rsp_err stable. On rsp_ready, go to IDLE.
- Commit: array read and write both happen on the edge entering RESP. rsp_rdata is registered on that same edge.
- Error conditions (rsp_err=1, no array write, rsp_rdata=0):
  - size==3;
  - size==1 with addr[0]=1;
  - size==2 with addr[1:0]!=0;
  - addr[31:ADDR_W] != 0.
- Store lanes:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all lanes.
  - Unaddressed lanes are untouched.
- Load: extract the addressed lane(s) and extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Word index into the array is addr[ADDR_W-1:2].
- Array contents are not reset.
- enable falling while in WAIT or RESP does not affect the in-flight access.
- One outstanding access only. Requests presented while req_ready=0 are neither sampled nor lost; the core holds them.

## Timing
- Reset (reset low, asynchronous): state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- Release: req_ready rises combinationally with reset high and enable high.
- Latency: acceptance edge to rsp_valid high = 1+WAIT_CYCLES cycles.
- Minimum request-to-request spacing = 2+WAIT_CYCLES cycles. req_ready is low in the cycle rsp_ready is taken and returns the cycle after.
- rsp_valid with rsp_ready tied high lasts exactly one cycle.
- Reset mid-WAIT aborts the access with no array write. Reset in RESP drops the pending response; the committed store remains.
- req_valid high during reset is ignored; req_ready is 0.

## Test plan
- Word round trip, WAIT_CYCLES=1: store 0xDEADBEEF @0x010, then load word @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises 2 cycles after each acceptance.
- Byte/half lanes: word 0x00000000 @0x020, store byte 0x80 @0x023, store half 0x7FFF @0x020, then:
  - load word -> 0x80007FFF;
  - signed byte @0x023 -> 0xFFFFFF80;
  - unsigned byte @0x023 -> 0x00000080;
  - signed half @0x020 -> 0x00007FFF.
- Errors: half load @0x021, word store @0x012, size=3, and any access @0x00001000 (ADDR_W=12) -> rsp_err=1, rsp_rdata=0. A following load of the targeted words shows prior contents unchanged.
- Backpressure: hold rsp_ready low 5 cycles -> rsp_valid, rsp_rdata and rsp_err are stable all 5 cycles and req_ready stays 0. Response completes on the rsp_ready cycle; req_ready returns 1 the next cycle.
- WAIT_CYCLES=0 and 7: measure acceptance-to-rsp_valid = 1 and 8 cycles. Drop enable during WAIT -> response still delivered, and req_ready stays 0 until enable returns.
- Reset mid-WAIT (WAIT_CYCLES=3) during store 0x12345678 @0x040 over old 0xCAFEF00D -> all outputs 0 immediately. Reload @0x040 after release -> 0xCAFEF00D.
